out_switch_arbiter: RTL and testbench
=====================================

// Module: out_switch_arbiter
// PURPOSE
//  Grants the shared output switch to one of four sources: W0/W1 (1536b wide path), N0/N1 (256b path).
//  The switch OR-merges its inputs, so at most one source may present tvalid in any cycle.
//  Sits between the compute groups and the switch; carries control signals only, no data.
//  Gates each source's tvalid/tready so the switch sees exactly one active source per burst.
// PARAMETERS
//  MAX_BURST  64                   max beats per grant; the burst is force-closed on the last beat
//  CNT_W      $clog2(MAX_BURST)    width of the beat counter
// PORTS
//  clk               in   1  single clock
//  rst_n             in   1  reset, asynchronous assert, active-low
//  en                in   1  1 = new grants allowed; 0 = the current burst completes, then no new grants
//  s_w_tvalid[1:0]   in   2  wide source valids (W0, W1)
//  s_w_tlast[1:0]    in   2  wide source end-of-burst
//  s_w_tready[1:0]   out  2  gated ready to the wide sources
//  s_n_tvalid[1:0]   in   2  256b source valids (N0, N1)
//  s_n_tlast[1:0]    in   2  256b source end-of-burst
//  s_n_tready[1:0]   out  2  gated ready to the 256b sources
//  sw_w_tvalid[1:0]  out  2  gated valids driven to the switch wide inputs
//  sw_n_tvalid[1:0]  out  2  gated valids driven to the switch 256b inputs
//  m_g_tready        in   1  switch g (1280b) output ready
//  m_h_tready        in   1  switch h (256b) output ready
//  busy              out  1  a grant is active
//  grant_id          out  2  granted source: 0=W0, 1=W1, 2=N0, 3=N1 (valid while busy)
//  beat_cnt          out  CNT_W  handshakes completed in the current burst
// BEHAVIOUR
//  Reset (async, rst_n=0) values:
//   - state=IDLE; busy=0; grant_id=0; beat_cnt=0; rr_last=3 (W0 has first priority).
//   - All sw_*_tvalid=0 and all s_*_tready=0, combinationally from the registered state.
//   - Reset mid-burst aborts the burst immediately; the aborted source sees its ready drop.
//  FSM with states IDLE and BUSY:
//   - IDLE: if en=1 and any s_*_tvalid=1, pick the first requester after rr_last (order 0,1,2,3, wrap).
//     Register grant_id and go to BUSY on the next edge. No pass-through is allowed in IDLE.
//   - BUSY: forward only the granted source (its switch valid = its s_*_tvalid); all other switch valids = 0.
//     Ready for a granted wide source = m_g_tready & m_h_tready; for a granted 256b source = m_h_tready.
//     Non-granted sources get ready=0.
//   - Handshake = granted valid & gated ready; each handshake increments beat_cnt.
//   - Burst end = handshake with tlast=1, or handshake when beat_cnt==MAX_BURST-1.
//     On burst end: go to IDLE, set rr_last=grant_id, clear beat_cnt.
//  Timing:
//   - Minimum one bubble cycle between bursts (IDLE cycle); grant latency = 1 cycle from request in IDLE.
//   - A request arriving in the same cycle as a burst end is seen in the following IDLE cycle.
//   - Valid deasserted mid-burst: the grant is held, with no timeout.
//   - en deasserted mid-burst has no effect until burst end; en=0 in IDLE keeps the FSM in IDLE.
//  Width rule: beat_cnt never reaches MAX_BURST and wraps to 0 only at burst end.
//  Sole requester: re-granted every burst, with a one-cycle bubble between bursts.
// TESTING
//  1. W0 alone, 4 beats, tlast on beat 4 -> grant_id=0 one cycle later, sw_w_tvalid=01, 4 handshakes,
//     busy drops the cycle after beat 4.
//  2. All 4 requesting continuously, tlast each beat -> grant order 0,1,2,3,0; sw valids one-hot or zero
//     on every cycle.
//  3. N1 burst with no tlast, MAX_BURST=64 -> forced close after beat 64; beat_cnt peaks at 63, then 0;
//     N1 is re-granted after 1 bubble.
//  4. W1 granted, m_h_tready=0, m_g_tready=1 -> s_w_tready[1]=0, no handshakes; after 3 cycles m_h_tready=1
//     -> beats resume.
//  5. rst_n pulsed low mid-burst of N0 (beat_cnt=5) -> busy=0, all readies/valids 0 asynchronously;
//     after release W0 is granted first.
//  6. en=0 during a W0 burst, W1 requesting -> W0 completes; no new grant until en=1; then W1 is granted
//     1 cycle later.

Source files
------------

// File: rtl/out_switch_arbiter.sv
// Round-robin grant of the shared output switch to W0/W1/N0/N1.
// Control only: gates valid/ready so one source drives the switch per burst.
module out_switch_arbiter #(
  parameter int MAX_BURST = 64,
  parameter int CNT_W     = $clog2(MAX_BURST)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       s_w_tvalid,
  input  logic [1:0]       s_w_tlast,
  output logic [1:0]       s_w_tready,
  input  logic [1:0]       s_n_tvalid,
  input  logic [1:0]       s_n_tlast,
  output logic [1:0]       s_n_tready,
  output logic [1:0]       sw_w_tvalid,
  output logic [1:0]       sw_n_tvalid,
  input  logic             m_g_tready,
  input  logic             m_h_tready,
  output logic             busy,
  output logic [1:0]       grant_id,
  output logic [CNT_W-1:0] beat_cnt
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       gid_q, gid_d;
  logic [1:0]       rr_q, rr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0] req;
  logic [3:0] lst;
  logic [3:0] sel;
  logic [1:0] c1, c2, c3, pick;
  logic       g_valid, g_ready, g_last;
  logic       hs, cnt_max, burst_end;

  // Index order 0=W0, 1=W1, 2=N0, 3=N1.
  assign req = {s_n_tvalid, s_w_tvalid};
  assign lst = {s_n_tlast, s_w_tlast};

  // First requester after the last granted source, wrapping.
  always_comb begin
    c1   = rr_q + 2'd1;
    c2   = rr_q + 2'd2;
    c3   = rr_q + 2'd3;
    pick = rr_q;
    if (req[c1])      pick = c1;
    else if (req[c2]) pick = c2;
    else if (req[c3]) pick = c3;
  end

  // Granted-source handshake and burst termination.
  always_comb begin
    busy      = (state_q == BUSY);
    g_valid   = busy & req[gid_q];
    g_ready   = gid_q[1] ? m_h_tready
                         : (m_g_tready & m_h_tready);
    g_last    = lst[gid_q];
    hs        = g_valid & g_ready;
    cnt_max   = (cnt_q == CNT_W'(MAX_BURST - 1));
    burst_end = hs & (g_last | cnt_max);
  end

  // Only the granted source reaches the switch; all others are gated off.
  always_comb begin
    sel         = busy ? (4'd1 << gid_q) : 4'd0;
    sw_w_tvalid = sel[1:0] & s_w_tvalid;
    sw_n_tvalid = sel[3:2] & s_n_tvalid;
    s_w_tready  = sel[1:0] & {2{g_ready}};
    s_n_tready  = sel[3:2] & {2{g_ready}};
    grant_id    = gid_q;
    beat_cnt    = cnt_q;
  end

  // Next-state: grant from IDLE, count beats and close bursts in BUSY.
  always_comb begin
    state_d = state_q;
    gid_d   = gid_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (en && (req != 4'd0)) begin
          gid_d   = pick;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (burst_end) begin
          state_d = IDLE;
          rr_d    = gid_q;
          cnt_d   = '0;
        end else if (hs) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any burst in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gid_q   <= 2'd0;
      rr_q    <= 2'd3;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gid_q   <= gid_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_out_switch_arbiter.sv
// Bench for out_switch_arbiter: directed bursts from a small source model,
// expected grants and beats queued up front, a negedge monitor compares.
module tb_out_switch_arbiter;

  localparam int MB = 64;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [1:0]    s_w_tvalid, s_w_tlast, s_w_tready;
  logic [1:0]    s_n_tvalid, s_n_tlast, s_n_tready;
  logic [1:0]    sw_w_tvalid, sw_n_tvalid;
  logic          m_g_tready, m_h_tready;
  logic          busy;
  logic [1:0]    grant_id;
  logic [CW-1:0] beat_cnt;

  out_switch_arbiter #(.MAX_BURST(MB)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .s_w_tvalid(s_w_tvalid),
    .s_w_tlast(s_w_tlast),
    .s_w_tready(s_w_tready),
    .s_n_tvalid(s_n_tvalid),
    .s_n_tlast(s_n_tlast),
    .s_n_tready(s_n_tready),
    .sw_w_tvalid(sw_w_tvalid),
    .sw_n_tvalid(sw_n_tvalid),
    .m_g_tready(m_g_tready),
    .m_h_tready(m_h_tready),
    .busy(busy),
    .grant_id(grant_id),
    .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    g;
    logic [CW-1:0] c;
  } beat_t;

  logic [1:0] gq[$];
  beat_t      bq[$];

  int checks = 0;
  int errors = 0;

  // source model: valid, burst length (0 = never tlast), beat and burst counts
  bit v[4];
  int len[4];
  int cnt[4];
  int nb[4];

  logic          s_busy;
  logic [1:0]    s_gid, s_sww, s_rw;
  logic [CW-1:0] s_cnt;
  logic          prev_busy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic tl(input int i);
    return (len[i] != 0) && (cnt[i] == len[i] - 1);
  endfunction

  task automatic drive();
    s_w_tvalid = {v[1], v[0]};
    s_n_tvalid = {v[3], v[2]};
    s_w_tlast  = {tl(1), tl(0)};
    s_n_tlast  = {tl(3), tl(2)};
  endtask

  task automatic cycle();
    logic [3:0] h;
    @(negedge clk);
    s_busy = busy;
    s_gid  = grant_id;
    s_sww  = sw_w_tvalid;
    s_rw   = s_w_tready;
    s_cnt  = beat_cnt;
    h = {s_n_tready, s_w_tready} & {s_n_tvalid, s_w_tvalid};
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (h[i]) begin
        if (tl(i)) begin
          cnt[i] = 0;
          nb[i]  = nb[i] - 1;
          if (nb[i] <= 0) v[i] = 1'b0;
        end else begin
          cnt[i] = cnt[i] + 1;
        end
      end
    end
    drive();
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while ((s_busy || v[0] || v[1] || v[2] || v[3]) && n < bound);
    chk("idle_timeout", 32'(s_busy || v[0] || v[1] || v[2] || v[3]), 0);
  endtask

  task automatic push_beats(input logic [1:0] g, input int first,
                            input int n);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.g = g;
      b.c = CW'(first + k);
      bq.push_back(b);
    end
  endtask

  // Monitor: grant on busy rise, one beat per handshake, one-hot switch valids.
  always @(negedge clk) begin
    logic [3:0] h;
    beat_t      b;
    chk("sw_onehot",
        32'($countones({sw_n_tvalid, sw_w_tvalid}) <= 1), 1);
    if (busy && !prev_busy) begin
      if (gq.size() == 0) chk("unexpected_grant", 32'(grant_id), 32'hff);
      else chk("grant_id", 32'(grant_id), 32'(gq.pop_front()));
    end
    if (!busy && prev_busy) chk("cnt_clear", 32'(beat_cnt), 0);
    h = {s_n_tready, s_w_tready} & {s_n_tvalid, s_w_tvalid};
    if (h != 4'd0) begin
      chk("hs_onehot", 32'($countones(h) == 1), 1);
      if (bq.size() == 0) begin
        chk("unexpected_beat", 32'(grant_id), 32'hff);
      end else begin
        b = bq.pop_front();
        chk("beat_gid", 32'(grant_id), 32'(b.g));
        chk("beat_cnt", 32'(beat_cnt), 32'(b.c));
      end
    end
    prev_busy <= busy;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    en = 1'b1;
    m_g_tready = 1'b1;
    m_h_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      v[i] = 1'b0; len[i] = 0; cnt[i] = 0; nb[i] = 0;
    end
    // W0 already requesting while in reset: nothing may pass
    v[0] = 1'b1; len[0] = 4; nb[0] = 1;
    drive();
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_gid", 32'(grant_id), 0);
    chk("rst_cnt", 32'(beat_cnt), 0);
    chk("rst_outs", 32'({sw_w_tvalid, sw_n_tvalid, s_w_tready, s_n_tready}), 0);

    // 1: W0 alone, 4 beats
    gq.push_back(2'd0);
    push_beats(2'd0, 0, 4);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle();
    chk("t1_no_pass", 32'({s_busy, s_sww}), 0);
    cycle();
    chk("t1_busy", 32'(s_busy), 1);
    chk("t1_sww", 32'(s_sww), 32'b01);
    repeat (3) cycle();
    cycle();
    chk("t1_busy_drop", 32'(s_busy), 0);

    // 2: all four, single-beat bursts; order 0,1,2,3,0 from reset
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      v[i] = 1'b1; len[i] = 1; cnt[i] = 0; nb[i] = 1;
    end
    nb[0] = 2;
    drive();
    for (int k = 0; k < 5; k++) begin
      gq.push_back(2'(k));
      push_beats(2'(k), 0, 1);
    end
    wait_idle(60);

    // 3: N1 without tlast, forced close at 64 beats, re-granted
    v[3] = 1'b1; len[3] = 0; cnt[3] = 0; nb[3] = 1;
    drive();
    gq.push_back(2'd3);
    push_beats(2'd3, 0, 64);
    gq.push_back(2'd3);
    push_beats(2'd3, 0, 10);
    repeat (65) cycle();
    cycle();
    chk("t3_bubble", 32'(s_busy), 0);
    repeat (10) cycle();
    v[3] = 1'b0;
    drive();
    repeat (3) cycle();
    chk("t3_hold_busy", 32'(s_busy), 1);
    chk("t3_hold_gid", 32'(s_gid), 3);
    chk("t3_hold_cnt", 32'(s_cnt), 10);
    len[3] = cnt[3] + 1;
    v[3] = 1'b1;
    drive();
    push_beats(2'd3, 10, 1);
    wait_idle(20);

    // 4: W1 stalled by m_h_tready
    m_h_tready = 1'b0;
    v[1] = 1'b1; len[1] = 3; cnt[1] = 0; nb[1] = 1;
    drive();
    gq.push_back(2'd1);
    push_beats(2'd1, 0, 3);
    cycle();
    cycle();
    chk("t4_ready_low", 32'(s_rw), 0);
    chk("t4_sww", 32'(s_sww), 32'b10);
    cycle();
    cycle();
    chk("t4_stall_cnt", 32'(s_cnt), 0);
    m_h_tready = 1'b1;
    cycle();
    chk("t4_ready_up", 32'(s_rw), 32'b10);
    wait_idle(20);

    // 5: reset during N0 burst at beat_cnt=5
    v[2] = 1'b1; len[2] = 0; cnt[2] = 0; nb[2] = 1;
    drive();
    gq.push_back(2'd2);
    push_beats(2'd2, 0, 5);
    repeat (6) cycle();
    chk("t5_cnt5", 32'(beat_cnt), 5);
    rst_n = 1'b0;
    #1;
    chk("t5_async_busy", 32'(busy), 0);
    chk("t5_async_outs",
        32'({sw_w_tvalid, sw_n_tvalid, s_w_tready, s_n_tready, beat_cnt}), 0);
    v[2] = 1'b0; cnt[2] = 0;
    v[0] = 1'b1; len[0] = 1; cnt[0] = 0; nb[0] = 1;
    v[3] = 1'b1; len[3] = 1; cnt[3] = 0; nb[3] = 1;
    drive();
    gq.push_back(2'd0);
    push_beats(2'd0, 0, 1);
    gq.push_back(2'd3);
    push_beats(2'd3, 0, 1);
    cycle();
    rst_n = 1'b1;
    cycle();
    cycle();
    chk("t5_first_gid", 32'({s_busy, s_gid}), 32'b100);
    wait_idle(20);

    // 6: en dropped during W0 burst with W1 waiting
    v[0] = 1'b1; len[0] = 4; cnt[0] = 0; nb[0] = 1;
    drive();
    gq.push_back(2'd0);
    push_beats(2'd0, 0, 4);
    gq.push_back(2'd1);
    push_beats(2'd1, 0, 1);
    cycle();
    v[1] = 1'b1; len[1] = 1; cnt[1] = 0; nb[1] = 1;
    en = 1'b0;
    drive();
    repeat (4) cycle();
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("t6_no_grant", 32'(s_busy), 0);
    end
    en = 1'b1;
    cycle();
    chk("t6_latency", 32'(s_busy), 0);
    cycle();
    chk("t6_w1_gid", 32'({s_busy, s_gid}), 32'b101);
    wait_idle(20);

    chk("grants_left", 32'(gq.size()), 0);
    chk("beats_left", 32'(bq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
